// File: rtl/clk_enable_gen.sv
// Multi-channel clock-enable generator: per-channel tick strobes and divided
// square-wave levels derived from the system clock, with glitch-free divisor updates.
module clk_enable_gen #(
  parameter int  NUM_CH      = 4,
  parameter int  DIV_W       = 16,
  parameter int  DEFAULT_DIV = 2,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              sync,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] level,
  output logic [NUM_CH-1:0] pending
);

  localparam logic [DIV_W-1:0] DEF_DIV = DIV_W'(DEFAULT_DIV);

  // Out-of-range channel numbers are always accepted and then dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg_ch == CH_W'(i)) begin
        cfg_ready = !pending[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] pdiv;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W:0]   half;
    logic             wrap;
    logic             load;
    logic             tick_q;
    logic             level_q;
    logic             pend_q;

    // Half-period uses one extra bit so the maximum divisor cannot overflow.
    always_comb begin
      period   = (div == '0) ? DIV_W'(1) : div;
      wrap     = (cnt == period - DIV_W'(1));
      cnt_next = wrap ? '0 : cnt + DIV_W'(1);
      half     = ({1'b0, period} + (DIV_W + 1)'(1)) >> 1;
      load     = cfg_valid && cfg_ready && (cfg_ch == CH_W'(g));
    end

    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt     <= '0;
        div     <= DEF_DIV;
        pdiv    <= DEF_DIV;
        pend_q  <= 1'b0;
        tick_q  <= 1'b0;
        level_q <= 1'b0;
      end else begin
        if (sync || !ch_en[g]) begin
          cnt     <= '0;
          tick_q  <= 1'b0;
          level_q <= 1'b0;
          if (pend_q) begin
            div    <= pdiv;
            pend_q <= 1'b0;
          end
        end else begin
          cnt     <= cnt_next;
          tick_q  <= wrap;
          level_q <= ({1'b0, cnt_next} < half);
          if (wrap && pend_q) begin
            div    <= pdiv;
            pend_q <= 1'b0;
          end
        end
        // A load never meets an apply: cfg_ready is low while pending.
        if (load) begin
          pdiv   <= cfg_div;
          pend_q <= 1'b1;
        end
      end
    end

    assign tick[g]    = tick_q;
    assign level[g]   = level_q;
    assign pending[g] = pend_q;
  end

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: a behavioural model feeds a scoreboard
// every cycle, and each scenario task also checks the documented timing points.
module tb_clk_enable_gen;

  localparam int NUM_CH      = 3;
  localparam int DIV_W       = 8;
  localparam int DEFAULT_DIV = 2;
  localparam int CH_W        = 2;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              sync = 1'b0;
  logic              cfg_valid = 1'b0;
  logic              cfg_ready;
  logic [CH_W-1:0]   cfg_ch = '0;
  logic [DIV_W-1:0]  cfg_div = '0;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] level;
  logic [NUM_CH-1:0] pending;

  clk_enable_gen #(
    .NUM_CH(NUM_CH),
    .DIV_W(DIV_W),
    .DEFAULT_DIV(DEFAULT_DIV)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .ch_en(ch_en),
    .sync(sync),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .tick(tick),
    .level(level),
    .pending(pending)
  );

  always #5 clk = ~clk;

  typedef logic [3*NUM_CH-1:0] obs_t;

  int   n_checks = 0;
  int   n_pass = 0;
  obs_t sb[$];
  obs_t exp_v;

  int                m_cnt[NUM_CH];
  int                m_div[NUM_CH];
  int                m_pdiv[NUM_CH];
  logic [NUM_CH-1:0] m_pend = '0;
  logic [NUM_CH-1:0] m_tick = '0;
  logic [NUM_CH-1:0] m_level = '0;

  // Model the edge from the inputs currently driven, queue the outputs it
  // predicts, then move one cycle forward and settle away from the edge.
  task automatic advance();
    int   p;
    int   idx;
    logic rdy;
    idx = int'(cfg_ch);
    rdy = 1'b1;
    if (idx < NUM_CH) rdy = !m_pend[idx];
    for (int i = 0; i < NUM_CH; i++) begin
      p = (m_div[i] == 0) ? 1 : m_div[i];
      if (!reset_n) begin
        m_cnt[i] = 0; m_div[i] = DEFAULT_DIV; m_pend[i] = 1'b0;
        m_tick[i] = 1'b0; m_level[i] = 1'b0;
      end else begin
        if (sync || !ch_en[i]) begin
          if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 1'b0; end
          m_cnt[i] = 0; m_tick[i] = 1'b0; m_level[i] = 1'b0;
        end else begin
          m_tick[i] = (m_cnt[i] == p - 1);
          if (m_tick[i]) begin
            m_cnt[i] = 0;
            if (m_pend[i]) begin m_div[i] = m_pdiv[i]; m_pend[i] = 1'b0; end
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
          m_level[i] = (2 * m_cnt[i] < p);
        end
        if (cfg_valid && rdy && idx == i) begin
          m_pdiv[i] = int'(cfg_div); m_pend[i] = 1'b1;
        end
      end
    end
    sb.push_back({m_tick, m_level, m_pend});
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; ch_en = '1; sync = 1'b1; cfg_valid = 1'b1; cfg_ch = '0; cfg_div = 8'd9;
    advance();
    exp_v = sb.pop_front();
    n_checks++;
    if ({tick, level, pending} !== exp_v)
      $display("[TB] FAIL sb_reset got %b want %b", {tick, level, pending}, exp_v);
    else n_pass++;
    n_checks++;
    if ({tick, level, pending} !== '0)
      $display("[TB] FAIL reset_outputs got %b want 0", {tick, level, pending});
    else n_pass++;
    n_checks++;
    if (cfg_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", cfg_ready);
    else n_pass++;
  endtask

  task automatic test_default();
    logic [6:0] t_h, l_h;
    reset_n = 1'b1; sync = 1'b0; cfg_valid = 1'b0; ch_en = 3'b001;
    t_h = '0; l_h = '0;
    t_h[0] = tick[0]; l_h[0] = level[0];
    for (int k = 0; k < 6; k++) begin
      advance();
      exp_v = sb.pop_front();
      n_checks++;
      if ({tick, level, pending} !== exp_v)
        $display("[TB] FAIL sb_default cycle %0d got %b want %b", k + 1, {tick, level, pending}, exp_v);
      else n_pass++;
      t_h[k+1] = tick[0]; l_h[k+1] = level[0];
    end
    n_checks++;
    if (t_h !== 7'b1010100) $display("[TB] FAIL default_ticks got %b want %b", t_h, 7'b1010100);
    else n_pass++;
    n_checks++;
    if (l_h !== 7'b1010100) $display("[TB] FAIL default_level got %b want %b", l_h, 7'b1010100);
    else n_pass++;
  endtask

  task automatic test_reconfig();
    logic [15:0] t_h, l_h, p_h;
    t_h = '0; l_h = '0; p_h = '0;
    for (int k = -3; k < 15; k++) begin
      case (k)
        -3: begin reset_n = 1'b0; ch_en = '0; cfg_valid = 1'b0; sync = 1'b0; end
        -2: begin reset_n = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4; end
        -1: cfg_valid = 1'b0;
        0:  ch_en = 3'b001;
        5: begin
          cfg_valid = 1'b1; cfg_div = 8'd3;
          n_checks++;
          if (cfg_ready !== 1'b1) $display("[TB] FAIL reconfig_ready_idle got %b want 1", cfg_ready);
          else n_pass++;
        end
        6: begin
          cfg_valid = 1'b0;
          n_checks++;
          if (cfg_ready !== 1'b0) $display("[TB] FAIL reconfig_ready_busy got %b want 0", cfg_ready);
          else n_pass++;
        end
        default: ;
      endcase
      advance();
      exp_v = sb.pop_front();
      n_checks++;
      if ({tick, level, pending} !== exp_v)
        $display("[TB] FAIL sb_reconfig cycle %0d got %b want %b", k + 1, {tick, level, pending}, exp_v);
      else n_pass++;
      if (k >= -1) begin
        t_h[k+1] = tick[0]; l_h[k+1] = level[0]; p_h[k+1] = pending[0];
      end
    end
    n_checks++;
    if (t_h !== 16'h4910) $display("[TB] FAIL reconfig_ticks got %h want 4910", t_h);
    else n_pass++;
    n_checks++;
    if (p_h !== 16'h00C0) $display("[TB] FAIL reconfig_pending got %h want 00c0", p_h);
    else n_pass++;
    n_checks++;
    if (l_h[7:0] !== 8'b00110010) $display("[TB] FAIL p4_level got %b want 00110010", l_h[7:0]);
    else n_pass++;
    n_checks++;
    if (l_h[10:8] !== 3'b011) $display("[TB] FAIL p3_level got %b want 011", l_h[10:8]);
    else n_pass++;
  endtask

  task automatic test_p1();
    int hits1, hits2;
    hits1 = 0; hits2 = 0;
    for (int k = 0; k < 25; k++) begin
      case (k)
        0:  begin cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd0; end
        1:  cfg_valid = 1'b0;
        12: begin cfg_valid = 1'b1; cfg_div = 8'd1; end
        13: cfg_valid = 1'b0;
        default: ;
      endcase
      advance();
      exp_v = sb.pop_front();
      n_checks++;
      if ({tick, level, pending} !== exp_v)
        $display("[TB] FAIL sb_p1 cycle %0d got %b want %b", k + 1, {tick, level, pending}, exp_v);
      else n_pass++;
      if (k + 1 >= 6 && k + 1 <= 12 && tick[0] && level[0]) hits1++;
      if (k + 1 >= 15 && tick[0] && level[0]) hits2++;
    end
    n_checks++;
    if (hits1 != 7) $display("[TB] FAIL div0_steady got %0d want 7", hits1);
    else n_pass++;
    n_checks++;
    if (hits2 != 11) $display("[TB] FAIL div1_steady got %0d want 11", hits2);
    else n_pass++;
  endtask

  task automatic test_sync();
    logic [18:0] t0_h, t1_h, l0_h, l1_h;
    t0_h = '0; t1_h = '0; l0_h = '0; l1_h = '0;
    for (int k = -4; k < 18; k++) begin
      case (k)
        -4: begin reset_n = 1'b0; ch_en = '0; sync = 1'b0; cfg_valid = 1'b0; end
        -3: begin reset_n = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd5; end
        -2: begin cfg_ch = 2'd1; cfg_div = 8'd3; end
        -1: cfg_valid = 1'b0;
        0:  ch_en = 3'b011;
        9:  sync = 1'b1;
        10: sync = 1'b0;
        15: sync = 1'b1;
        16: sync = 1'b0;
        default: ;
      endcase
      advance();
      exp_v = sb.pop_front();
      n_checks++;
      if ({tick, level, pending} !== exp_v)
        $display("[TB] FAIL sb_sync cycle %0d got %b want %b", k + 1, {tick, level, pending}, exp_v);
      else n_pass++;
      if (k >= -1) begin
        t0_h[k+1] = tick[0]; t1_h[k+1] = tick[1]; l0_h[k+1] = level[0]; l1_h[k+1] = level[1];
      end
    end
    n_checks++;
    if ({t0_h[10], t1_h[10], l0_h[10], l1_h[10]} !== 4'b0000)
      $display("[TB] FAIL sync_clear got %b want 0000", {t0_h[10], t1_h[10], l0_h[10], l1_h[10]});
    else n_pass++;
    n_checks++;
    if (t0_h !== 19'h08020) $display("[TB] FAIL sync_ticks_ch0 got %h want 08020", t0_h);
    else n_pass++;
    n_checks++;
    if (t1_h !== 19'h02248) $display("[TB] FAIL sync_ticks_ch1 got %h want 02248", t1_h);
    else n_pass++;
    n_checks++;
    if (t1_h[16] !== 1'b0) $display("[TB] FAIL sync_wrap_suppress got %b want 0", t1_h[16]);
    else n_pass++;
  endtask

  task automatic test_disable();
    logic [14:0] t2_h, l2_h, p2_h;
    t2_h = '0; l2_h = '0; p2_h = '0;
    for (int k = 0; k < 14; k++) begin
      case (k)
        0: ch_en = 3'b111;
        2: begin cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 8'd7; end
        3: begin cfg_valid = 1'b0; ch_en = 3'b011; end
        5: ch_en = 3'b111;
        default: ;
      endcase
      advance();
      exp_v = sb.pop_front();
      n_checks++;
      if ({tick, level, pending} !== exp_v)
        $display("[TB] FAIL sb_disable cycle %0d got %b want %b", k + 1, {tick, level, pending}, exp_v);
      else n_pass++;
      t2_h[k+1] = tick[2]; l2_h[k+1] = level[2]; p2_h[k+1] = pending[2];
    end
    n_checks++;
    if (p2_h[4:3] !== 2'b01) $display("[TB] FAIL disable_pending got %b want 01", p2_h[4:3]);
    else n_pass++;
    n_checks++;
    if ({t2_h[4], l2_h[4]} !== 2'b00) $display("[TB] FAIL disable_outputs got %b want 00", {t2_h[4], l2_h[4]});
    else n_pass++;
    n_checks++;
    if (t2_h[14:5] !== 10'b0010000000) $display("[TB] FAIL reenable_tick got %b want 0010000000", t2_h[14:5]);
    else n_pass++;
  endtask

  task automatic test_oor_reset();
    logic [NUM_CH-1:0] tv[13];
    logic [NUM_CH-1:0] lv[13];
    logic [NUM_CH-1:0] pv[13];
    for (int k = 0; k < 12; k++) begin
      case (k)
        0: begin
          cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 8'd9;
          n_checks++;
          if (cfg_ready !== 1'b1) $display("[TB] FAIL oor_ready got %b want 1", cfg_ready);
          else n_pass++;
        end
        1: begin cfg_valid = 1'b0; cfg_ch = 2'd0; end
        4: reset_n = 1'b0;
        5: begin reset_n = 1'b1; ch_en = 3'b111; end
        default: ;
      endcase
      advance();
      exp_v = sb.pop_front();
      n_checks++;
      if ({tick, level, pending} !== exp_v)
        $display("[TB] FAIL sb_oor_reset cycle %0d got %b want %b", k + 1, {tick, level, pending}, exp_v);
      else n_pass++;
      tv[k+1] = tick; lv[k+1] = level; pv[k+1] = pending;
    end
    n_checks++;
    if (pv[1] !== 3'b000) $display("[TB] FAIL oor_pending got %b want 000", pv[1]);
    else n_pass++;
    n_checks++;
    if ({tv[5], lv[5], pv[5]} !== '0) $display("[TB] FAIL midreset_outputs got %b want 0", {tv[5], lv[5], pv[5]});
    else n_pass++;
    for (int c = 6; c <= 12; c++) begin
      n_checks++;
      if (tv[c] !== ((c % 2 == 1) ? 3'b111 : 3'b000))
        $display("[TB] FAIL default_restored cycle %0d got %b want %b", c, tv[c], (c % 2 == 1) ? 3'b111 : 3'b000);
      else n_pass++;
    end
  endtask

  task automatic test_max_div();
    int   n_tick, n_high;
    logic t255, t510;
    n_tick = 0; n_high = 0; t255 = 1'b0; t510 = 1'b0;
    for (int k = -3; k < 512; k++) begin
      case (k)
        -3: begin reset_n = 1'b0; ch_en = '0; cfg_valid = 1'b0; end
        -2: begin reset_n = 1'b1; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd255; end
        -1: cfg_valid = 1'b0;
        0:  ch_en = 3'b001;
        default: ;
      endcase
      advance();
      exp_v = sb.pop_front();
      n_checks++;
      if ({tick, level, pending} !== exp_v)
        $display("[TB] FAIL sb_max cycle %0d got %b want %b", k + 1, {tick, level, pending}, exp_v);
      else n_pass++;
      if (k >= 0 && tick[0]) n_tick++;
      if (k >= 0 && k + 1 <= 255 && level[0]) n_high++;
      if (k + 1 == 255) t255 = tick[0];
      if (k + 1 == 510) t510 = tick[0];
    end
    n_checks++;
    if (n_tick != 2 || !t255 || !t510)
      $display("[TB] FAIL max_ticks got %0d (c255=%b c510=%b) want 2 (1 1)", n_tick, t255, t510);
    else n_pass++;
    n_checks++;
    if (n_high != 128) $display("[TB] FAIL max_level_high got %0d want 128", n_high);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_default();
    test_reconfig();
    test_p1();
    test_sync();
    test_disable();
    test_oor_reset();
    test_max_div();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
